// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath strobes per state, and traps on illegal opcodes or memory wait timeouts.
module multicycle_control #(
  parameter int OPCODE_W    = 11,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                imem_read,
  output logic                ir_write,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                alu_src,
  output logic                update_sreg,
  output logic                readreg2_control,
  output logic                write_reg_src,
  output logic [1:0]          alu_op,
  output logic [1:0]          mem_to_reg,
  output logic [2:0]          branch_op,
  output logic [2:0]          state,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic                instr_done
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'b000,
    S_DECODE  = 3'b001,
    S_EXECUTE = 3'b010,
    S_MEM     = 3'b011,
    S_WB      = 3'b100,
    S_TRAP    = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_CMP, C_CMPI, C_LOAD, C_STORE,
    C_B, C_BL, C_BCOND, C_CBZ, C_CBNZ, C_BR
  } op_class_t;

  localparam logic [2:0] BCOND_OP_ALU  = 3'b101;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: classify = C_R;
      11'b1001000100?, 11'b1101000100?,
      11'b1001001000?, 11'b1011001000?: classify = C_I;
      11'b11101011000:                  classify = C_CMP;
      11'b1111000100?:                  classify = C_CMPI;
      11'b11111000010:                  classify = C_LOAD;
      11'b11111000000:                  classify = C_STORE;
      11'b000101?????:                  classify = C_B;
      11'b100101?????:                  classify = C_BL;
      11'b01010100???:                  classify = C_BCOND;
      11'b10110100???:                  classify = C_CBZ;
      11'b10110101???:                  classify = C_CBNZ;
      11'b11010110000:                  classify = C_BR;
      default:                          classify = C_NONE;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPCODE_W-1:0] op_q;
  logic [1:0]          cause_q, cause_d;
  logic                boot_q;
  op_class_t           cls;

  assign cls        = classify(op_q);
  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

  // boot_q holds the FSM idle, strobes low, for the cycle right after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      cause_q <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      boot_q  <= 1'b0;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    cause_d          = cause_q;
    imem_read        = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    reg_write        = 1'b0;
    alu_src          = 1'b0;
    update_sreg      = 1'b0;
    readreg2_control = 1'b0;
    write_reg_src    = 1'b0;
    alu_op           = 2'b00;
    mem_to_reg       = 2'b00;
    branch_op        = 3'b000;
    instr_done       = 1'b0;

    if (!reset && !boot_q) begin
      if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
        case (cls)
          C_R:     alu_op = 2'b10;
          C_I:     begin alu_src = 1'b1; alu_op = 2'b10; end
          C_CMP:   begin update_sreg = 1'b1; alu_op = 2'b10; end
          C_CMPI:  begin alu_src = 1'b1; update_sreg = 1'b1; alu_op = 2'b10; end
          C_LOAD:  begin alu_src = 1'b1; mem_to_reg = 2'b01; end
          C_STORE: begin alu_src = 1'b1; readreg2_control = 1'b1; end
          C_BL:    begin write_reg_src = 1'b1; alu_op = 2'b01; mem_to_reg = 2'b10; end
          C_CBZ, C_CBNZ: begin readreg2_control = 1'b1; alu_op = 2'b01; end
          C_B, C_BCOND, C_BR: alu_op = 2'b01;
          default: ;
        endcase
      end

      case (state_q)
        S_FETCH, S_MEM: begin
          if (state_q == S_FETCH) begin
            imem_read = 1'b1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
          end else begin
            mem_read   = (cls == C_LOAD);
            mem_write  = (cls == C_STORE);
            instr_done = (cls == C_STORE) && mem_ready;
          end
          if (mem_ready) begin
            if (state_q == S_FETCH) state_d = S_DECODE;
            else                    state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DECODE: begin
          if (classify(opcode) == C_NONE) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cls)
            C_R, C_I, C_BL:   state_d = S_WB;
            C_LOAD, C_STORE:  state_d = S_MEM;
            default:          begin state_d = S_FETCH; instr_done = 1'b1; end
          endcase
          case (cls)
            C_B, C_BL: branch_op = 3'b001;
            C_BCOND:   branch_op = 3'b010;
            C_CBZ:     branch_op = 3'b011;
            C_CBNZ:    branch_op = 3'b100;
            C_BR:      branch_op = BCOND_OP_ALU;
            default:   branch_op = 3'b000;
          endcase
          pc_write = (branch_op != 3'b000);
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction's expected per-cycle outputs are
// built from a class table (fetch waits, execute, optional memory phase, optional writeback).
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        mem_ready;
  logic        imem_read, ir_write, pc_write, mem_read, mem_write, reg_write;
  logic        alu_src, update_sreg, readreg2_control, write_reg_src;
  logic [1:0]  alu_op, mem_to_reg, trap_cause;
  logic [2:0]  branch_op, state;
  logic        trap, instr_done;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(11), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src(alu_src), .update_sreg(update_sreg), .readreg2_control(readreg2_control),
    .write_reg_src(write_reg_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .branch_op(branch_op), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instr_done(instr_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Classes: 0 R, 1 I, 2 CMP, 3 CMPI, 4 LDUR, 5 STUR, 6 B, 7 BL, 8 BCOND, 9 CBZ, 10 CBNZ, 11 BR
  // Returns {alu_src, update_sreg, readreg2_control, write_reg_src, alu_op, mem_to_reg, branch_op}
  function automatic logic [10:0] class_fields(input int c);
    case (c)
      0:  return {8'b0000_10_00, 3'b000};
      1:  return {8'b1000_10_00, 3'b000};
      2:  return {8'b0100_10_00, 3'b000};
      3:  return {8'b1100_10_00, 3'b000};
      4:  return {8'b1000_00_01, 3'b000};
      5:  return {8'b1010_00_00, 3'b000};
      6:  return {8'b0000_01_00, 3'b001};
      7:  return {8'b0001_01_10, 3'b001};
      8:  return {8'b0000_01_00, 3'b010};
      9:  return {8'b0010_01_00, 3'b011};
      10: return {8'b0010_01_00, 3'b100};
      default: return {8'b0000_01_00, 3'b101};
    endcase
  endfunction

  function automatic logic [10:0] gen_op(input int c);
    logic [10:0] rt [4];
    logic [9:0]  it [4];
    logic [31:0] r;
    rt = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    it = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    r  = $urandom;
    case (c)
      0:  return rt[r[1:0]];
      1:  return {it[r[1:0]], r[4]};
      2:  return 11'b11101011000;
      3:  return {10'b1111000100, r[4]};
      4:  return OP_LDUR;
      5:  return OP_STUR;
      6:  return {6'b000101, r[8:4]};
      7:  return {6'b100101, r[8:4]};
      8:  return {8'b01010100, r[6:4]};
      9:  return {8'b10110100, r[6:4]};
      10: return {8'b10110101, r[6:4]};
      default: return 11'b11010110000;
    endcase
  endfunction

  // Strobe vector order: {imem_read, ir_write, pc_write, mem_read, mem_write, reg_write, instr_done}
  task automatic cyc(input logic mr, input logic [10:0] op, input logic [2:0] es,
                     input logic [6:0] estb, input logic [7:0] efld, input logic [2:0] ebr,
                     input logic [2:0] etrap);
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    cycle++;
    #1;
    chk("state", 32'(state), 32'(es));
    chk("strobes", 32'({imem_read, ir_write, pc_write, mem_read, mem_write, reg_write, instr_done}),
        32'(estb));
    chk("fields", 32'({alu_src, update_sreg, readreg2_control, write_reg_src, alu_op, mem_to_reg}),
        32'(efld));
    chk("branch_op", 32'(branch_op), 32'(ebr));
    chk("trap", 32'({trap, trap_cause}), 32'(etrap));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'($urandom);
    opcode = 11'($urandom);
    cycle++;
    #1;
    chk("rst_strobes", 32'({imem_read, ir_write, pc_write, mem_read, mem_write, reg_write,
        instr_done, branch_op}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'($urandom);
    cycle++;
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_strobes", 32'({imem_read, ir_write, pc_write, mem_read, mem_write, reg_write,
        instr_done, branch_op}), 32'd0);
    chk("post_rst_fields", 32'({alu_src, update_sreg, readreg2_control, write_reg_src, alu_op,
        mem_to_reg}), 32'd0);
    chk("post_rst_trap", 32'({trap, trap_cause}), 32'd0);
  endtask

  task automatic fetch_decode(input int fw, input logic [10:0] op);
    for (int i = 0; i <= fw; i++)
      cyc(i == fw, 11'($urandom), 3'd0, {1'b1, i == fw, i == fw, 4'b0}, 8'd0, 3'd0, 3'd0);
    cyc(1'($urandom), op, 3'd1, 7'd0, 8'd0, 3'd0, 3'd0);
  endtask

  task automatic execute(input int c);
    logic [10:0] f;
    logic        done_ex;
    f = class_fields(c);
    done_ex = (c == 2 || c == 3 || c == 6 || c >= 8);
    cyc(1'($urandom), 11'($urandom), 3'd2, {2'b00, c >= 6, 3'b000, done_ex}, f[10:3], f[2:0], 3'd0);
  endtask

  task automatic run_instr_op(input int c, input logic [10:0] op, input int fw, input int dw);
    logic [10:0] f;
    f = class_fields(c);
    fetch_decode(fw, op);
    execute(c);
    if (c == 4 || c == 5)
      for (int i = 0; i <= dw; i++)
        cyc(i == dw, 11'($urandom), 3'd3,
            {3'b000, c == 4, c == 5, 1'b0, (c == 5) && (i == dw)}, f[10:3], 3'd0, 3'd0);
    if (c == 0 || c == 1 || c == 4 || c == 7)
      cyc(1'($urandom), 11'($urandom), 3'd4, 7'b0000011, f[10:3], 3'd0, 3'd0);
  endtask

  task automatic trap_cycles(input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom), 11'($urandom), 3'd7, 7'd0, 8'd0, 3'd0, {1'b1, cause});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    do_reset();

    run_instr_op(0, OP_ADD, 0, 0);
    run_instr_op(4, OP_LDUR, 0, 3);
    run_instr_op(5, OP_STUR, 0, 0);
    run_instr_op(9, gen_op(9), 0, 0);

    for (int n = 0; n < 120; n++) begin
      int c;
      c = int'($urandom_range(0, 11));
      run_instr_op(c, gen_op(c), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    run_instr_op(0, gen_op(0), 15, 0);
    run_instr_op(4, OP_LDUR, 0, 15);
    run_instr_op(5, OP_STUR, 15, 15);

    fetch_decode(0, 11'b00000000000);
    trap_cycles(6, 2'b01);
    do_reset();
    fetch_decode(1, 11'b11111111111);
    trap_cycles(2, 2'b01);
    do_reset();

    for (int i = 0; i < 16; i++)
      cyc(1'b0, 11'($urandom), 3'd0, 7'b1000000, 8'd0, 3'd0, 3'd0);
    trap_cycles(4, 2'b10);
    do_reset();

    fetch_decode(0, OP_LDUR);
    execute(4);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 11'($urandom), 3'd3, 7'b0001000, class_fields(4) >> 3, 3'd0, 3'd0);
    trap_cycles(3, 2'b10);
    do_reset();

    fetch_decode(0, OP_LDUR);
    execute(4);
    cyc(1'b0, 11'($urandom), 3'd3, 7'b0001000, class_fields(4) >> 3, 3'd0, 3'd0);
    do_reset();
    run_instr_op(7, gen_op(7), 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
